// File: rtl/queue_calculator_p.sv
// Queue calculator: a ring-buffer operand store with an ALU that pops from the head and pushes to the back.
// Optional feature: define QCALC_SATURATE_EN to make ADD/SUB/MUL saturate instead of wrapping.
module queue_calculator_p #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           in,
   input  logic [2:0]                 op,
   input  logic                       apply,
   output logic                       ready,
   output logic [WIDTH-1:0]           tail,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       valid,
   output logic [1:0]                 err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = $clog2(WIDTH);

   typedef logic [PW-1:0] ptr_t;

   typedef enum logic [2:0] {
      OP_PUSH = 3'd0,
      OP_POP  = 3'd1,
      OP_ADD  = 3'd2,
      OP_SUB  = 3'd3,
      OP_MUL  = 3'd4,
      OP_DIV  = 3'd5,
      OP_MOD  = 3'd6,
      OP_DUP  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_UNDERFLOW = 2'd1,
      ERR_OVERFLOW  = 2'd2,
      ERR_DIV_ZERO  = 2'd3
   } err_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_WRITE  = 2'd2
   } state_e;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic ptr_t ptr_dec(input ptr_t p);
      return (p == '0) ? ptr_t'(DEPTH - 1) : p - 1'b1;
   endfunction

   logic [WIDTH-1:0] mem [DEPTH];
   ptr_t             rd_ptr, wr_ptr;
   logic [CW-1:0]    count_q;
   err_e             err_q;
   state_e           state, state_next;

   logic [DW-1:0]    div_cnt;
   logic [WIDTH-1:0] div_b, div_quo, div_rem;
   logic             div_is_mod;

   op_e              op_q;
   logic [WIDTH-1:0] a_val, b_val;
   logic [WIDTH-1:0] add_res, sub_res, mul_res;

   logic             push_en;
   logic [1:0]       pop_n;
   logic [WIDTH-1:0] wr_data;
   logic             err_load;
   err_e             err_next;
   logic             div_start;
   logic [CW-1:0]    need;

   logic [WIDTH:0]   div_trial, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem_next;

   assign op_q  = op_e'(op);
   assign a_val = mem[rd_ptr];
   assign b_val = mem[ptr_inc(rd_ptr)];

`ifdef QCALC_SATURATE_EN
   logic [WIDTH:0]     sum_w, diff_w;
   logic [2*WIDTH-1:0] prod_w;

   assign sum_w   = {1'b0, a_val} + {1'b0, b_val};
   assign diff_w  = {1'b0, a_val} - {1'b0, b_val};
   assign prod_w  = {{WIDTH{1'b0}}, a_val} * {{WIDTH{1'b0}}, b_val};
   assign add_res = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
   assign sub_res = diff_w[WIDTH] ? '0 : diff_w[WIDTH-1:0];
   assign mul_res = (|prod_w[2*WIDTH-1:WIDTH]) ? '1 : prod_w[WIDTH-1:0];
`else
   assign add_res = a_val + b_val;
   assign sub_res = a_val - b_val;
   assign mul_res = a_val * b_val;
`endif

   // Restoring step: shift in the next dividend bit, subtract if it fits.
   assign div_trial    = {div_rem, div_quo[WIDTH-1]};
   assign div_diff     = div_trial - {1'b0, div_b};
   assign div_ge       = !div_diff[WIDTH];
   assign div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      state_next = state;
      push_en    = 1'b0;
      pop_n      = 2'd0;
      wr_data    = in;
      err_load   = 1'b0;
      err_next   = ERR_NONE;
      div_start  = 1'b0;
      need       = '0;
      case (state)
         S_IDLE: begin
            if (apply) begin
               case (op_q)
                  OP_PUSH:        need = '0;
                  OP_POP, OP_DUP: need = CW'(1);
                  default:        need = CW'(2);
               endcase
               err_load = 1'b1;
               if (count_q < need) begin
                  err_next = ERR_UNDERFLOW;
               end else if ((op_q == OP_PUSH || op_q == OP_DUP) && full) begin
                  err_next = ERR_OVERFLOW;
               end else if ((op_q == OP_DIV || op_q == OP_MOD) && b_val == '0) begin
                  err_next = ERR_DIV_ZERO;
               end else begin
                  case (op_q)
                     OP_PUSH: push_en = 1'b1;
                     OP_POP:  pop_n   = 2'd1;
                     OP_DUP: begin
                        push_en = 1'b1;
                        wr_data = a_val;
                     end
                     OP_ADD, OP_SUB, OP_MUL: begin
                        pop_n   = 2'd2;
                        push_en = 1'b1;
                        wr_data = (op_q == OP_ADD) ? add_res :
                                  (op_q == OP_SUB) ? sub_res : mul_res;
                     end
                     default: begin
                        // Status stays frozen until the divider writes back.
                        err_load   = 1'b0;
                        div_start  = 1'b1;
                        state_next = S_DIVIDE;
                     end
                  endcase
               end
            end
         end
         S_DIVIDE: begin
            if (div_cnt == DW'(WIDTH - 1)) state_next = S_WRITE;
         end
         S_WRITE: begin
            pop_n      = 2'd2;
            push_en    = 1'b1;
            wr_data    = div_is_mod ? div_rem : div_quo;
            err_load   = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count_q    <= '0;
         err_q      <= ERR_NONE;
         div_cnt    <= '0;
         div_b      <= '0;
         div_quo    <= '0;
         div_rem    <= '0;
         div_is_mod <= 1'b0;
      end else begin
         if (push_en) wr_ptr <= ptr_inc(wr_ptr);
         case (pop_n)
            2'd1:    rd_ptr <= ptr_inc(rd_ptr);
            2'd2:    rd_ptr <= ptr_inc(ptr_inc(rd_ptr));
            default: rd_ptr <= rd_ptr;
         endcase
         count_q <= count_q + CW'(push_en) - CW'(pop_n);
         if (err_load) err_q <= err_next;
         if (div_start) begin
            div_quo    <= a_val;
            div_rem    <= '0;
            div_b      <= b_val;
            div_is_mod <= (op_q == OP_MOD);
            div_cnt    <= '0;
         end else if (state == S_DIVIDE) begin
            div_quo <= {div_quo[WIDTH-2:0], div_ge};
            div_rem <= div_rem_next;
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // NOTE: storage has no reset; entries are only observable through count, which reset clears.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= wr_data;
   end

   assign ready = (state == S_IDLE);
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign valid = (err_q == ERR_NONE);
   assign err   = err_q;
   assign head  = empty ? '0 : a_val;
   assign tail  = empty ? '0 : mem[ptr_dec(wr_ptr)];

endmodule
